// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared constants and types for the register-file write-back scheduler.
//   REG_ADDR_W : register address width (32 architectural registers)
//   XLEN       : data width
//   sched_st_e : scheduler state encoding (IDLE=0, DIV_PEND=1, RESULT_HELD=2)
package regfile_wb_scheduler_pkg;

   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned XLEN       = 32;

   typedef enum logic [1:0] {
      StIdle       = 2'd0,
      StDivPend    = 2'd1,
      StResultHeld = 2'd2
   } sched_st_e;

endpackage

// File: rtl/regfile_wb_scheduler_wb_hold_reg.sv
// wb_hold_reg: single-entry buffer for a divider result that lost the
// register-file port to an in-order pipeline write.
//   clk     : clock, rising edge
//   clear_i : synchronous clear (wins over load)
//   load_i  : capture rd_i/data_i and mark the entry valid
//   valid_o : entry holds a result
//   rd_o    : buffered destination register
//   data_o  : buffered result data
module wb_hold_reg
   import regfile_wb_scheduler_pkg::*;
(
   input  logic                  clk,
   input  logic                  clear_i,
   input  logic                  load_i,
   input  logic [REG_ADDR_W-1:0] rd_i,
   input  logic [XLEN-1:0]       data_i,
   output logic                  valid_o,
   output logic [REG_ADDR_W-1:0] rd_o,
   output logic [XLEN-1:0]       data_o
);

   logic                  valid_q;
   logic [REG_ADDR_W-1:0] rd_q;
   logic [XLEN-1:0]       data_q;

   always_ff @(posedge clk) begin
      if (clear_i) begin
         valid_q <= 1'b0;
         rd_q    <= '0;
         data_q  <= '0;
      end else if (load_i) begin
         valid_q <= 1'b1;
         rd_q    <= rd_i;
         data_q  <= data_i;
      end
   end

   assign valid_o = valid_q;
   assign rd_o    = rd_q;
   assign data_o  = data_q;

endmodule

// File: rtl/regfile_wb_scheduler.sv
// regfile_wb_scheduler: arbitrates the single register-file write port between
// the in-order pipeline write-back (absolute priority) and a multi-cycle
// MUL/DIV unit, buffering a displaced divider result and stalling decode on
// hazards against the outstanding/held destination register.
// Ports:
//   clk, rst                        : clock, synchronous active-high reset
//   pipe_wr_en/addr/data            : pipeline write-back request
//   div_issue, div_issue_rd         : decode issues a divide and its rd
//   div_valid/rd/data, div_ready    : divider result handshake
//   dec_rs1/rs2/rd, dec_stall       : decode operands and stall request
//   rf_wr_en/addr/data              : register-file write port
//   busy                            : a divide is outstanding or held
//   byp_rs1_hit/rs2_hit, byp_data   : held-result bypass
// Configuration: define DIV_RESULT_BYPASS_EN to forward a held result to
// decode source operands instead of stalling on them.
module regfile_wb_scheduler
   import regfile_wb_scheduler_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  pipe_wr_en,
   input  logic [REG_ADDR_W-1:0] pipe_wr_addr,
   input  logic [XLEN-1:0]       pipe_wr_data,
   input  logic                  div_issue,
   input  logic [REG_ADDR_W-1:0] div_issue_rd,
   input  logic                  div_valid,
   input  logic [REG_ADDR_W-1:0] div_rd,
   input  logic [XLEN-1:0]       div_data,
   output logic                  div_ready,
   input  logic [REG_ADDR_W-1:0] dec_rs1,
   input  logic [REG_ADDR_W-1:0] dec_rs2,
   input  logic [REG_ADDR_W-1:0] dec_rd,
   output logic                  dec_stall,
   output logic                  rf_wr_en,
   output logic [REG_ADDR_W-1:0] rf_wr_addr,
   output logic [XLEN-1:0]       rf_wr_data,
   output logic                  busy,
   output logic                  byp_rs1_hit,
   output logic                  byp_rs2_hit,
   output logic [XLEN-1:0]       byp_data
);

   sched_st_e             state_q;
   logic [REG_ADDR_W-1:0] pend_rd_q;

   logic                  hold_valid;
   logic [REG_ADDR_W-1:0] hold_rd;
   logic [XLEN-1:0]       hold_data;

   logic st_pend, st_held;
   logic div_fire;
   logic hold_load, hold_clear;

   assign st_pend  = (state_q == StDivPend);
   assign st_held  = (state_q == StResultHeld);
   // Results arriving with nothing outstanding are dropped.
   assign div_fire = div_valid && st_pend;
   assign hold_load  = div_fire && pipe_wr_en;
   assign hold_clear = rst || (st_held && !pipe_wr_en);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         pend_rd_q <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (div_issue) begin
                  state_q   <= StDivPend;
                  pend_rd_q <= div_issue_rd;
               end
            end
            StDivPend: begin
               if (div_valid) begin
                  state_q <= pipe_wr_en ? StResultHeld : StIdle;
               end
            end
            StResultHeld: begin
               if (!pipe_wr_en) begin
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   wb_hold_reg u_hold (
      .clk     (clk),
      .clear_i (hold_clear),
      .load_i  (hold_load),
      .rd_i    (div_rd),
      .data_i  (div_data),
      .valid_o (hold_valid),
      .rd_o    (hold_rd),
      .data_o  (hold_data)
   );

   // Write-port arbitration: pipeline, then a fresh divider result, then the
   // held entry. Writes to x0 are squashed and the port reads as all zero.
   logic [REG_ADDR_W-1:0] wr_addr;
   logic [XLEN-1:0]       wr_data;
   logic                  wr_req;

   always_comb begin
      wr_req  = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      if (pipe_wr_en) begin
         wr_req  = 1'b1;
         wr_addr = pipe_wr_addr;
         wr_data = pipe_wr_data;
      end else if (div_fire) begin
         wr_req  = 1'b1;
         wr_addr = div_rd;
         wr_data = div_data;
      end else if (st_held && hold_valid) begin
         wr_req  = 1'b1;
         wr_addr = hold_rd;
         wr_data = hold_data;
      end
   end

   // Hazard compare against whichever rd is live in the current state.
   logic [REG_ADDR_W-1:0] live_rd;
   logic                  live;
   logic                  m_rs1, m_rs2, m_rd;
   logic                  src_stall;

   assign live    = st_pend || st_held;
   assign live_rd = st_pend ? pend_rd_q : hold_rd;
   assign m_rs1   = live && (dec_rs1 != '0) && (dec_rs1 == live_rd);
   assign m_rs2   = live && (dec_rs2 != '0) && (dec_rs2 == live_rd);
   assign m_rd    = live && (dec_rd != '0) && (dec_rd == live_rd);

`ifdef DIV_RESULT_BYPASS_EN
   // A held result is forwarded to sources, so only a pending rd blocks them.
   assign src_stall = st_pend && (m_rs1 || m_rs2);

   always_comb begin
      byp_rs1_hit = 1'b0;
      byp_rs2_hit = 1'b0;
      byp_data    = '0;
      if (!rst && st_held) begin
         byp_rs1_hit = m_rs1;
         byp_rs2_hit = m_rs2;
         if (m_rs1 || m_rs2) begin
            byp_data = hold_data;
         end
      end
   end
`else
   assign src_stall   = m_rs1 || m_rs2;
   assign byp_rs1_hit = 1'b0;
   assign byp_rs2_hit = 1'b0;
   assign byp_data    = '0;
`endif

   // Outputs are forced to their idle values while reset is asserted.
   always_comb begin
      rf_wr_en   = 1'b0;
      rf_wr_addr = '0;
      rf_wr_data = '0;
      if (!rst && wr_req && (wr_addr != '0)) begin
         rf_wr_en   = 1'b1;
         rf_wr_addr = wr_addr;
         rf_wr_data = wr_data;
      end
   end

   assign div_ready = rst || !st_held;
   assign busy      = !rst && (state_q != StIdle);
   assign dec_stall = !rst && (state_q != StIdle) && (div_issue || src_stall || m_rd);

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
module tb_regfile_wb_scheduler;

   logic        clk = 1'b0;
   logic        rst;
   logic        pipe_wr_en;
   logic [4:0]  pipe_wr_addr;
   logic [31:0] pipe_wr_data;
   logic        div_issue;
   logic [4:0]  div_issue_rd;
   logic        div_valid;
   logic [4:0]  div_rd;
   logic [31:0] div_data;
   logic        div_ready;
   logic [4:0]  dec_rs1, dec_rs2, dec_rd;
   logic        dec_stall;
   logic        rf_wr_en;
   logic [4:0]  rf_wr_addr;
   logic [31:0] rf_wr_data;
   logic        busy;
   logic        byp_rs1_hit, byp_rs2_hit;
   logic [31:0] byp_data;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: a divide is either outstanding (with its rd) or its
   // result sits in a one-deep buffer; otherwise the scheduler is free.
   bit        m_pending;
   bit [4:0]  m_pend_rd;
   bit        m_held;
   bit [4:0]  m_held_rd;
   bit [31:0] m_held_data;

   always #5 clk = ~clk;

   regfile_wb_scheduler dut (
      .clk          (clk),
      .rst          (rst),
      .pipe_wr_en   (pipe_wr_en),
      .pipe_wr_addr (pipe_wr_addr),
      .pipe_wr_data (pipe_wr_data),
      .div_issue    (div_issue),
      .div_issue_rd (div_issue_rd),
      .div_valid    (div_valid),
      .div_rd       (div_rd),
      .div_data     (div_data),
      .div_ready    (div_ready),
      .dec_rs1      (dec_rs1),
      .dec_rs2      (dec_rs2),
      .dec_rd       (dec_rd),
      .dec_stall    (dec_stall),
      .rf_wr_en     (rf_wr_en),
      .rf_wr_addr   (rf_wr_addr),
      .rf_wr_data   (rf_wr_data),
      .busy         (busy),
      .byp_rs1_hit  (byp_rs1_hit),
      .byp_rs2_hit  (byp_rs2_hit),
      .byp_data     (byp_data)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      rst = 1'b0; pipe_wr_en = 1'b0; pipe_wr_addr = '0; pipe_wr_data = '0;
      div_issue = 1'b0; div_issue_rd = '0; div_valid = 1'b0; div_rd = '0;
      div_data = '0; dec_rs1 = '0; dec_rs2 = '0; dec_rd = '0;
   endtask

   // Called just after a falling edge with inputs applied: checks every output
   // against the model, then advances the model across the rising edge.
   task automatic step(input string tag);
      bit        e_wen, e_stall, e_ready, e_busy, e_h1, e_h2, fire, srcs_block;
      bit [4:0]  e_addr, w_addr;
      bit [31:0] e_data, w_data, e_byp;
      bit        w_req, live;
      bit [4:0]  lrd;
      bit        hit1, hit2, hitd;
      #1;
      fire  = div_valid && m_pending;
      w_req = 1'b0; w_addr = 0; w_data = 0;
      if (pipe_wr_en)  begin w_req = 1; w_addr = pipe_wr_addr; w_data = pipe_wr_data; end
      else if (fire)   begin w_req = 1; w_addr = div_rd;       w_data = div_data;     end
      else if (m_held) begin w_req = 1; w_addr = m_held_rd;    w_data = m_held_data;  end
      live = m_pending || m_held;
      lrd  = m_pending ? m_pend_rd : m_held_rd;
      hit1 = live && dec_rs1 != 0 && dec_rs1 == lrd;
      hit2 = live && dec_rs2 != 0 && dec_rs2 == lrd;
      hitd = live && dec_rd  != 0 && dec_rd  == lrd;
`ifdef DIV_RESULT_BYPASS_EN
      srcs_block = m_pending && (hit1 || hit2);
      e_h1  = m_held && hit1;
      e_h2  = m_held && hit2;
      e_byp = (e_h1 || e_h2) ? m_held_data : 32'd0;
`else
      srcs_block = hit1 || hit2;
      e_h1 = 0; e_h2 = 0; e_byp = 0;
`endif
      e_wen   = w_req && w_addr != 0;
      e_addr  = e_wen ? w_addr : 5'd0;
      e_data  = e_wen ? w_data : 32'd0;
      e_ready = !m_held;
      e_busy  = live;
      e_stall = live && (div_issue || srcs_block || hitd);
      if (rst) begin
         e_wen = 0; e_addr = 0; e_data = 0; e_ready = 1; e_busy = 0; e_stall = 0;
         e_h1 = 0; e_h2 = 0; e_byp = 0;
      end
      check({tag, ".rf_wr_en"},   32'(rf_wr_en),    32'(e_wen));
      check({tag, ".rf_wr_addr"}, 32'(rf_wr_addr),  32'(e_addr));
      check({tag, ".rf_wr_data"}, rf_wr_data,       e_data);
      check({tag, ".div_ready"},  32'(div_ready),   32'(e_ready));
      check({tag, ".busy"},       32'(busy),        32'(e_busy));
      check({tag, ".dec_stall"},  32'(dec_stall),   32'(e_stall));
      check({tag, ".byp_rs1"},    32'(byp_rs1_hit), 32'(e_h1));
      check({tag, ".byp_rs2"},    32'(byp_rs2_hit), 32'(e_h2));
      check({tag, ".byp_data"},   byp_data,         e_byp);
      @(posedge clk);
      if (rst) begin
         m_pending = 0; m_pend_rd = 0; m_held = 0; m_held_rd = 0; m_held_data = 0;
      end else if (!live) begin
         if (div_issue) begin m_pending = 1; m_pend_rd = div_issue_rd; end
      end else if (fire) begin
         m_pending = 0;
         if (pipe_wr_en) begin m_held = 1; m_held_rd = div_rd; m_held_data = div_data; end
      end else if (m_held && !pipe_wr_en) begin
         m_held = 0;
      end
      @(negedge clk);
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      rst = 1'b1;
      pipe_wr_en = 1'b1; pipe_wr_addr = 5'd2; pipe_wr_data = 32'h77;  // squashed in reset
      m_pending = 0; m_pend_rd = 0; m_held = 0; m_held_rd = 0; m_held_data = 0;
      @(negedge clk);
      step("reset0");
      rst = 1'b1; step("reset1");
      step("post_reset");

      // Zero-latency write of a divider result when the port is free.
      div_issue = 1; div_issue_rd = 5'd5; step("w028_issue");
      step("w028_pend");
      div_valid = 1; div_rd = 5'd5; div_data = 32'h1234; step("w028_result");
      step("w028_idle");

      // Result displaced by the pipeline, then drained on the first free cycle.
      div_issue = 1; div_issue_rd = 5'd7; step("w029_issue");
      div_valid = 1; div_rd = 5'd7; div_data = 32'hAA;
      pipe_wr_en = 1; pipe_wr_addr = 5'd3; pipe_wr_data = 32'h55; step("w029_collide");
      pipe_wr_en = 1; pipe_wr_addr = 5'd8; pipe_wr_data = 32'h66; step("w029_held");
      step("w029_drain");
      step("w029_idle");

      // RAW hazard against the pending rd; x0 operands never stall.
      div_issue = 1; div_issue_rd = 5'd9; step("w030_issue");
      dec_rs2 = 5'd9; step("w030_raw");
      step("w030_zero");

      // Second issue while busy stalls and leaves pend_rd untouched.
      div_issue = 1; div_issue_rd = 5'd12; dec_rs1 = 5'd1; step("w031_reissue");
      dec_rs1 = 5'd9;  step("w031_old_rd");
      dec_rs1 = 5'd12; step("w031_new_rd");
      div_valid = 1; div_rd = 5'd0; div_data = 32'hDEAD; step("w031_x0");
      step("w031_idle");

      // Reset discards a held result.
      div_issue = 1; div_issue_rd = 5'd4; step("w032_issue");
      div_valid = 1; div_rd = 5'd4; div_data = 32'hCAFE;
      pipe_wr_en = 1; pipe_wr_addr = 5'd6; pipe_wr_data = 32'h1; step("w032_collide");
      rst = 1; step("w032_rst");
      step("w032_after");
      step("w032_after2");

      // Held rd=4 seen by decode: bypass or stall depending on build.
      div_issue = 1; div_issue_rd = 5'd4; step("w033_issue");
      div_valid = 1; div_rd = 5'd4; div_data = 32'hBEEF;
      pipe_wr_en = 1; pipe_wr_addr = 5'd10; pipe_wr_data = 32'h2; step("w033_collide");
      pipe_wr_en = 1; pipe_wr_addr = 5'd11; pipe_wr_data = 32'h3; dec_rs1 = 5'd4;
      step("w033_rs1");
      pipe_wr_en = 1; pipe_wr_addr = 5'd11; pipe_wr_data = 32'h3; dec_rd = 5'd4;
      step("w033_rd");
      step("w033_drain");

      // Random traffic over a small register range to provoke hazards.
      for (int i = 0; i < 3000; i++) begin
         rst          = ($urandom_range(0, 99) == 0);
         pipe_wr_en   = ($urandom_range(0, 2) == 0);
         pipe_wr_addr = 5'($urandom_range(0, 7));
         pipe_wr_data = $urandom;
         div_issue    = ($urandom_range(0, 3) == 0);
         div_issue_rd = 5'($urandom_range(0, 7));
         div_valid    = ($urandom_range(0, 3) == 0);
         div_rd       = 5'($urandom_range(0, 7));
         div_data     = $urandom;
         dec_rs1      = 5'($urandom_range(0, 7));
         dec_rs2      = 5'($urandom_range(0, 7));
         dec_rd       = 5'($urandom_range(0, 7));
         step("rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
